awb_gain_ctrl: RTL
==================

// Module: awb_gain_ctrl
// PURPOSE
//  Gray-world auto-white-balance controller that produces the per-channel gains for the white-balance multiplier stage.
//  - Accumulates R, G and B Bayer samples over one frame.
//  - At frame end, serially divides to get K_R = sumG/sumR and K_B = sumG/sumB; K_G is fixed at unity.
//  - Presents K_R/K_G/K_B with valid_gain_o; the gains are held stable between frames.
// PARAMETERS
//  ACC_W      24  accumulator width per channel; accumulators saturate at all-ones
//  GAIN_W     8   gain output width
//  GAIN_FRAC  6   gain fractional bits; unity = 1<<GAIN_FRAC = 64
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       reset, asynchronous, active-low
//  frame_start_i  in   1       1-cycle pulse, first cycle of a frame
//  frame_end_i    in   1       1-cycle pulse, last cycle of a frame
//  valid_i        in   1       sample qualifier
//  color_i        in   2       0=RED 1=GREEN 2=BLUE 3=ignored
//  value_i        in   8       sample value
//  K_R/K_G/K_B    out  GAIN_W  gains, unsigned Q(GAIN_W-GAIN_FRAC).GAIN_FRAC
//  valid_gain_o   out  1       gains valid; low after reset, high after the first update, then stays high
//  gain_upd_o     out  1       1-cycle pulse in the cycle new gains first appear
//  busy_o         out  1       high in every state except IDLE
//  drop_o         out  1       1-cycle pulse when a frame_start is ignored
// BEHAVIOUR
//  Reset values:
//  - K_R = K_G = K_B = UNITY.
//  - valid_gain_o, gain_upd_o, busy_o, drop_o = 0.
//  - Accumulators = 0; FSM in IDLE.
//  FSM: IDLE -> ACCUM -> DIV_R -> DIV_B -> UPDATE -> IDLE.
//  - IDLE: frame_start_i clears all three accumulators -> ACCUM.
//  - ACCUM:
//    - Each valid_i with color 0/1/2 adds value_i to that channel's accumulator (saturating).
//    - color 3 is discarded.
//    - frame_end_i -> DIV_R; a sample in the same cycle as frame_end_i is included.
//    - frame_start_i in ACCUM clears the accumulators and restarts ACCUM; it is not a drop.
//    - frame_start_i and frame_end_i in the same cycle: frame_end_i wins.
//  - DIV_R / DIV_B: serial restoring division, q = (sumG << GAIN_FRAC) / sumC.
//    - DIV_CYC = ACC_W + GAIN_FRAC cycles per channel, one quotient bit per cycle.
//    - Quotient > 2^GAIN_W-1, or sumC == 0 -> saturate to 2^GAIN_W-1.
//    - sumG == 0 with sumC != 0 -> 0.
//    - valid_i is ignored. frame_start_i is ignored and pulses drop_o the next cycle.
//  - UPDATE (1 cycle): register K_R, K_B; K_G = UNITY; set valid_gain_o; pulse gain_upd_o -> IDLE.
//  Latency: frame_end_i sampled at edge 0 -> new gains and gain_upd_o visible after edge 2*DIV_CYC+1 (default 61).
//  Gain outputs change only at UPDATE; they are glitch-free registered outputs.
//  Reset mid-operation: everything returns to reset values immediately; the partial frame is lost.
//  valid_gain_o returns to 0 until the next full frame completes.
// CONFIGURATION
//  AWB_SMOOTH_EN defined:
//  - At UPDATE, K_x <= (K_x_old + q_x + 1) >> 1, i.e. rounded mean of the old gain and the new quotient.
//  - The first update after reset loads q_x directly.
//  AWB_SMOOTH_EN undefined:
//  - K_x <= q_x; no smoothing logic is instantiated.
// STRUCTURE
//  Package awb_pkg:
//  - color codes RED/GREEN/BLUE = 0/1/2.
//  - FSM state enum.
//  - UNITY = 1<<GAIN_FRAC.
//  - DIV_CYC function.
//  Sub-module awb_div: serial restoring divider.
//  - start/done handshake; dividend ACC_W+GAIN_FRAC bits, divisor ACC_W bits.
//  - Saturating GAIN_W-bit quotient; zero-divisor flag.
//  - Instantiated once and reused for R then B.
// TESTING
//  1 Frame of 100 R=100, 100 G=200, 100 B=50 -> K_R=128, K_G=64, K_B=255 (sat),
//    gain_upd_o exactly 61 cycles after frame_end_i.
//  2 Frame with equal R/G/B sums -> K_R=K_B=K_G=64, valid_gain_o rises and stays 1.
//  3 Frame with no BLUE samples and color_i=3 samples interleaved -> K_B=255,
//    color 3 samples have no effect on K_R.
//  4 frame_start_i pulsed during DIV_R -> drop_o pulses once, gains are from the original frame.
//    Next frame_start_i in IDLE is accepted.
//  5 rst_n asserted mid-DIV_B -> outputs at reset values immediately; a following full frame gives correct gains.
//  6 AWB_SMOOTH_EN: frames giving q_R=128 then 64 -> K_R=128 then 96.
//    Without the macro -> 128 then 64.

Source files
------------

// File: rtl/awb_pkg.sv
// awb_pkg: shared colour codes, FSM states, default widths and helpers for the gray-world AWB controller.
`timescale 1ns/1ps
package awb_pkg;
    typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, IGNORE = 2'd3} color_e;
    typedef enum logic [2:0] {IDLE, ACCUM, DIV_R, DIV_B, UPDATE} state_e;
    localparam int ACC_W_DEF = 24;
    localparam int GAIN_W_DEF = 8;
    localparam int GAIN_FRAC_DEF = 6;
    function automatic int unity(input int frac);
        return 1 << frac;
    endfunction
    function automatic int div_cyc(input int acc_w, input int frac);
        return acc_w + frac;
    endfunction
endpackage

// File: rtl/awb_div.sv
// awb_div: serial restoring divider, one quotient bit per cycle, saturating GAIN_W-bit quotient.
`timescale 1ns/1ps
module awb_div import awb_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ACC_W+GAIN_FRAC-1:0] dividend,
    input  logic [ACC_W-1:0]           divisor,
    output logic                       done,
    output logic [GAIN_W-1:0]          q,
    output logic                       dz
);
    localparam int DW = ACC_W + GAIN_FRAC;
    localparam int CW = $clog2(div_cyc(ACC_W, GAIN_FRAC));
    localparam logic [CW-1:0] LAST = CW'(div_cyc(ACC_W, GAIN_FRAC) - 1);
    logic [ACC_W-1:0] rem, den, rem_n;
    logic [DW-1:0] quo, quo_n;
    logic [ACC_W:0] shifted;
    logic [CW-1:0] cnt;
    logic run, ge;
    // quo_n is exposed so the final quotient is usable in the same cycle done is high
    always_comb begin
        shifted = {rem, quo[DW-1]};
        ge = shifted >= {1'b0, den};
        rem_n = ge ? ACC_W'(shifted - {1'b0, den}) : shifted[ACC_W-1:0];
        quo_n = {quo[DW-2:0], ge};
        done = run && cnt == LAST;
        dz = den == '0;
        q = (dz || |quo_n[DW-1:GAIN_W]) ? '1 : quo_n[GAIN_W-1:0];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            den <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            rem <= '0;
            quo <= dividend;
            den <= divisor;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
            run <= !done;
        end
endmodule

// File: rtl/awb_gain_ctrl.sv
// awb_gain_ctrl: gray-world AWB gain controller (K_R = sumG/sumR, K_B = sumG/sumB, K_G = unity).
// Define AWB_SMOOTH_EN to average each new gain with the previous one at update.
`timescale 1ns/1ps
module awb_gain_ctrl import awb_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start_i,
    input  logic              frame_end_i,
    input  logic              valid_i,
    input  logic [1:0]        color_i,
    input  logic [7:0]        value_i,
    output logic [GAIN_W-1:0] K_R,
    output logic [GAIN_W-1:0] K_G,
    output logic [GAIN_W-1:0] K_B,
    output logic              valid_gain_o,
    output logic              gain_upd_o,
    output logic              busy_o,
    output logic              drop_o
);
    localparam logic [GAIN_W-1:0] UNITY_G = GAIN_W'(unity(GAIN_FRAC));
    state_e state, state_n;
    logic [ACC_W-1:0] acc_r, acc_g, acc_b, acc_r_n, acc_g_n, acc_b_n;
    logic [GAIN_W-1:0] q_r, q_b, q_div, q_sat, k_r_n, k_b_n;
    logic clr, add, div_start, div_done, div_dz;
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] v);
        logic [ACC_W:0] s = {1'b0, a} + (ACC_W+1)'(v);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction
    // frame_end wins over a simultaneous frame_start, so the sample in that cycle still counts
    always_comb begin
        clr = frame_start_i && (state == IDLE || (state == ACCUM && !frame_end_i));
        add = state == ACCUM && valid_i;
        acc_r_n = clr ? '0 : (add && color_i == RED) ? sat_add(acc_r, value_i) : acc_r;
        acc_g_n = clr ? '0 : (add && color_i == GREEN) ? sat_add(acc_g, value_i) : acc_g;
        acc_b_n = clr ? '0 : (add && color_i == BLUE) ? sat_add(acc_b, value_i) : acc_b;
        div_start = (state == ACCUM && frame_end_i) || (state == DIV_R && div_done);
        q_sat = div_dz ? '1 : q_div;
        state_n = state;
        unique case (state)
            IDLE:    state_n = frame_start_i ? ACCUM : IDLE;
            ACCUM:   state_n = frame_end_i ? DIV_R : ACCUM;
            DIV_R:   state_n = div_done ? DIV_B : DIV_R;
            DIV_B:   state_n = div_done ? UPDATE : DIV_B;
            UPDATE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    awb_div #(.ACC_W(ACC_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) u_div (
        .clk(clk),
        .rst_n(rst_n),
        .start(div_start),
        .dividend({acc_g_n, {GAIN_FRAC{1'b0}}}),
        .divisor(state == ACCUM ? acc_r_n : acc_b_n),
        .done(div_done),
        .q(q_div),
        .dz(div_dz)
    );
`ifdef AWB_SMOOTH_EN
    function automatic logic [GAIN_W-1:0] smooth(input logic [GAIN_W-1:0] old_k, input logic [GAIN_W-1:0] new_q, input logic first);
        logic [GAIN_W:0] s = {1'b0, old_k} + {1'b0, new_q} + (GAIN_W+1)'(1);
        return first ? new_q : GAIN_W'(s >> 1);
    endfunction
    assign k_r_n = smooth(K_R, q_r, !valid_gain_o);
    assign k_b_n = smooth(K_B, q_b, !valid_gain_o);
`else
    assign k_r_n = q_r;
    assign k_b_n = q_b;
`endif
    assign K_G = UNITY_G;
    assign busy_o = state != IDLE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
            q_r <= '0;
            q_b <= '0;
            K_R <= UNITY_G;
            K_B <= UNITY_G;
            valid_gain_o <= 1'b0;
            gain_upd_o <= 1'b0;
            drop_o <= 1'b0;
        end else begin
            state <= state_n;
            acc_r <= acc_r_n;
            acc_g <= acc_g_n;
            acc_b <= acc_b_n;
            gain_upd_o <= state == UPDATE;
            drop_o <= (state == DIV_R || state == DIV_B) && frame_start_i;
            if (state == DIV_R && div_done) q_r <= q_sat;
            if (state == DIV_B && div_done) q_b <= q_sat;
            if (state == UPDATE) begin
                K_R <= k_r_n;
                K_B <= k_b_n;
                valid_gain_o <= 1'b1;
            end
        end
endmodule
